// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the two-requester memory
//               arbiter: FSM state encoding, requester IDs and the memory
//               command record that is driven onto the memory port.
// Ports       : (package - none)
// Revision    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUSY_CPU = 3'd1,
    ST_BUSY_DBG = 3'd2,
    ST_RESP_CPU = 3'd3,
    ST_RESP_DBG = 3'd4
  } state_e;

  // Requester identifiers; also the bit positions in the eligible vector
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // The command record is sized for the widest supported port; the top
  // zero-extends its inputs into it and slices its outputs back out.
  localparam int CMD_ADDR_MAX_W = 64;
  localparam int CMD_DATA_MAX_W = 64;

  typedef struct packed {
    logic                      we;
    logic [CMD_ADDR_MAX_W-1:0] addr;
    logic [CMD_DATA_MAX_W-1:0] wdata;
    logic [2:0]                size;
  } mem_cmd_t;

  localparam mem_cmd_t CMD_NONE = '0;

  // Assemble a command record from already-extended fields
  function automatic mem_cmd_t make_cmd(
    input logic                      we,
    input logic [CMD_ADDR_MAX_W-1:0] addr,
    input logic [CMD_DATA_MAX_W-1:0] wdata,
    input logic [2:0]                size
  );
    mem_cmd_t cmd;
    cmd.we    = we;
    cmd.addr  = addr;
    cmd.wdata = wdata;
    cmd.size  = size;
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin pick. When both inputs are
//               eligible the requester that did not win the last tie is
//               chosen; a single eligible input always wins.
// Ports       : eligible [1:0] in  - bit REQ_CPU / bit REQ_DBG eligibility
//               last_dbg       in  - 1 when DBG won the most recent tie
//               winner         out - granted requester ID (REQ_CPU/REQ_DBG)
//               valid          out - at least one requester is eligible
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_dbg,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |eligible;
    winner = REQ_CPU;
    if (&eligible) begin
      winner = last_dbg ? REQ_CPU : REQ_DBG;
    end else if (eligible[REQ_DBG]) begin
      winner = REQ_DBG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-ported memory between the CPU datapath and a
//               debug/program-loader port. One transaction at a time over a
//               req/ack handshake, round-robin on ties, memory command driven
//               for exactly one cycle, registered read data returned with a
//               one-cycle ack.
// Ports       : clk, rst (async, active-low)
//               cpu_req/we/addr/wdata/size in, cpu_ack/rdata/stall out
//               dbg_req/we/addr/wdata/size in, dbg_ack/rdata out
//               dbg_lock in - blocks CPU grants while high
//               mem_read_address/mem_write_address/mem_write_data/
//               mem_write_enable/mem_size_and_sign out, mem_read_data in
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_size,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [2:0]        dbg_size,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  input  logic              dbg_lock,

  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic [2:0]        mem_size_and_sign,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q, state_d;
  logic              last_dbg_q, last_dbg_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic [1:0]        w_eligible;
  logic              w_winner;
  logic              w_grant_valid;
  logic              w_cmd_unused;

  // The lock only masks the CPU request at arbitration time, so a CPU
  // transaction already past IDLE always runs to completion.
  assign w_eligible[REQ_CPU] = cpu_req & ~dbg_lock;
  assign w_eligible[REQ_DBG] = dbg_req;

  rr_arbiter2 u_rr (
    .eligible (w_eligible),
    .last_dbg (last_dbg_q),
    .winner   (w_winner),
    .valid    (w_grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    last_dbg_d  = last_dbg_q;
    cmd_d       = CMD_NONE;   // memory port is idle unless entering BUSY
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_valid) begin
          // The fairness flag only moves when there was real contention
          if (&w_eligible) begin
            last_dbg_d = w_winner;
          end
          if (w_winner == REQ_DBG) begin
            state_d = ST_BUSY_DBG;
            cmd_d   = make_cmd(dbg_we, CMD_ADDR_MAX_W'(dbg_addr),
                               CMD_DATA_MAX_W'(dbg_wdata), dbg_size);
          end else begin
            state_d = ST_BUSY_CPU;
            cmd_d   = make_cmd(cpu_we, CMD_ADDR_MAX_W'(cpu_addr),
                               CMD_DATA_MAX_W'(cpu_wdata), cpu_size);
          end
        end
      end
      ST_BUSY_CPU: begin
        if (!cmd_q.we) begin
          cpu_rdata_d = mem_read_data;
        end
        cpu_ack_d = 1'b1;
        state_d   = ST_RESP_CPU;
      end
      ST_BUSY_DBG: begin
        if (!cmd_q.we) begin
          dbg_rdata_d = mem_read_data;
        end
        dbg_ack_d = 1'b1;
        state_d   = ST_RESP_DBG;
      end
      ST_RESP_CPU, ST_RESP_DBG: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_dbg_q  <= 1'b1;    // CPU wins the first tie after reset
      cmd_q       <= CMD_NONE;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dbg_q  <= last_dbg_d;
      cmd_q       <= cmd_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // The command register is non-zero only during BUSY, and an asynchronous
  // reset clears it immediately, dropping the write enable mid-cycle.
  assign mem_read_address  = cmd_q.addr[ADDR_W-1:0];
  assign mem_write_address = cmd_q.addr[ADDR_W-1:0];
  assign mem_write_data    = cmd_q.wdata[DATA_W-1:0];
  assign mem_write_enable  = cmd_q.we;
  assign mem_size_and_sign = cmd_q.size;

  // Upper bits of the wide command record are always zero
  assign w_cmd_unused = ^cmd_q;

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               reference model predicts grant order, ack cycles and read
//               data; a monitor compares DUT outputs every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk, rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_size;
  logic        dbg_req, dbg_we, dbg_ack, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0]  dbg_size;
  logic [31:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic [2:0]  mem_size_and_sign;

  logic [31:0] tb_mem  [0:255];   // the memory the DUT talks to
  logic [31:0] ref_mem [0:255];   // reference model's view of memory

  assign mem_read_data = tb_mem[mem_read_address[9:2]];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_size(dbg_size), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_size_and_sign(mem_size_and_sign), .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      if (mem_write_enable) tb_mem[mem_write_address[9:2]] <= mem_write_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int ack_cyc; logic [31:0] rdata; } exp_t;
  typedef struct { int id; int cyc; } ev_t;
  exp_t cpu_q[$];
  exp_t dbg_q[$];
  ev_t  evs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A granted transaction occupies the memory during the next cycle, is
  // acknowledged the cycle after, and the arbiter can grant again one cycle
  // later: grant at edge k -> busy k+1, ack k+2, next grant at edge k+3.
  int          m_free, m_exec, m_busy_cyc, m_id;
  logic        m_last_dbg, m_pend, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [31:0] m_rd [2];
  logic        m_ce, m_de;
  exp_t        m_e;

  initial begin
    m_free = 0; m_last_dbg = 1'b1; m_pend = 1'b0; m_busy_cyc = -1;
    m_rd[0] = '0; m_rd[1] = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_free = 0; m_last_dbg = 1'b1; m_pend = 1'b0; m_busy_cyc = -1;
        m_rd[0] = '0; m_rd[1] = '0;
        cpu_q.delete(); dbg_q.delete();
      end else begin
        if (m_pend && cyc == m_exec) begin
          if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
          else      m_rd[m_id] = ref_mem[m_addr[9:2]];
          m_e.ack_cyc = cyc + 1;
          m_e.rdata   = m_rd[m_id];
          if (m_id == 0) cpu_q.push_back(m_e); else dbg_q.push_back(m_e);
          m_pend = 1'b0;
        end
        if (cyc >= m_free) begin
          m_ce = cpu_req && !dbg_lock;
          m_de = dbg_req;
          if (m_ce || m_de) begin
            if (m_ce && m_de) begin
              m_id = m_last_dbg ? 0 : 1;
              m_last_dbg = (m_id == 1);
            end else begin
              m_id = m_de ? 1 : 0;
            end
            if (m_id == 0) begin
              m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; m_size = cpu_size;
            end else begin
              m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; m_size = dbg_size;
            end
            m_pend = 1'b1; m_exec = cyc + 1; m_busy_cyc = cyc + 1; m_free = cyc + 3;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  logic mon_ec, mon_ed, mon_busy;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_ec = (cpu_q.size() > 0) && (cpu_q[0].ack_cyc == cyc);
        mon_ed = (dbg_q.size() > 0) && (dbg_q[0].ack_cyc == cyc);
        if (mon_ec || cpu_ack) check("cpu_ack", cpu_ack, mon_ec);
        if (mon_ec) begin check("cpu_rdata", cpu_rdata, cpu_q[0].rdata); void'(cpu_q.pop_front()); end
        if (mon_ed || dbg_ack) check("dbg_ack", dbg_ack, mon_ed);
        if (mon_ed) begin check("dbg_rdata", dbg_rdata, dbg_q[0].rdata); void'(dbg_q.pop_front()); end
        if (cpu_ack) evs.push_back('{0, cyc});
        if (dbg_ack) evs.push_back('{1, cyc});
        mon_busy = (m_busy_cyc == cyc);
        check("mem_we",    mem_write_enable,  mon_busy ? m_we    : 1'b0);
        check("mem_raddr", mem_read_address,  mon_busy ? m_addr  : 32'h0);
        check("mem_waddr", mem_write_address, mon_busy ? m_addr  : 32'h0);
        check("mem_wdata", mem_write_data,    mon_busy ? m_wdata : 32'h0);
        check("mem_size",  mem_size_and_sign, mon_busy ? m_size  : 3'h0);
        check("cpu_stall", cpu_stall, cpu_req & ~mon_ec);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transaction under the req/ack contract; req drops after the edge
  // that ends the ack cycle. A caller issuing again immediately keeps req high.
  task automatic issue(input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] s);
    int n;
    if (id == 0) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_size = s; cpu_req = 1'b1; end
    else         begin dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_size = s; dbg_req = 1'b1; end
    n = 0;
    while (!(id == 0 ? cpu_ack : dbg_ack) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout id=%0d: no ack after %0d cycles, expected an ack", id, n);
    end
    tick();
    if (id == 0) cpu_req = 1'b0; else dbg_req = 1'b0;
  endtask

  task automatic rand_issue(input int id);
    issue(id, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
          $urandom, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int base, t0, t1, cnt_c, cnt_d;
  int exp_ids [4];

  initial begin
    rst = 1'b0; dbg_lock = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_size = 0;
    for (int i = 0; i < 256; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    tb_mem[64] = 32'hDEADBEEF; ref_mem[64] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_mem_we", mem_write_enable, 0);
    check("rst_mem_raddr", mem_read_address, 0);
    check("rst_mem_waddr", mem_write_address, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_mem_size", mem_size_and_sign, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    rst = 1'b1;
    tick();

    // CPU read of preloaded word
    issue(0, 1'b0, 32'h100, 32'h0, 3'b010);
    check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // DBG write, then CPU read back
    issue(1, 1'b1, 32'h40, 32'h12345678, 3'b010);
    issue(0, 1'b0, 32'h40, 32'h0, 3'b010);
    check("t2_readback", cpu_rdata, 32'h12345678);

    // continuous contention: strict alternation, 3-cycle ack spacing
    base = evs.size();
    fork
      begin issue(0, 1'b0, 32'h100, 0, 3'b010); issue(0, 1'b0, 32'h40, 0, 3'b010); end
      begin issue(1, 1'b0, 32'h40, 0, 3'b010);  issue(1, 1'b0, 32'h100, 0, 3'b010); end
    join
    exp_ids = '{0, 1, 0, 1};
    check("t3_ack_count", evs.size() - base, 4);
    for (int i = 0; i < 4 && base + i < evs.size(); i++) begin
      check("t3_grant_order", evs[base + i].id, exp_ids[i]);
      if (i > 0) check("t3_ack_spacing", evs[base + i].cyc - evs[base + i - 1].cyc, 3);
    end

    // dbg_lock blocks the CPU for 12 cycles while DBG streams 4 transactions
    base = evs.size();
    t0 = cyc;
    dbg_lock = 1'b1;
    fork
      issue(0, 1'b0, 32'h100, 0, 3'b010);
      begin
        for (int i = 0; i < 4; i++) rand_issue(1);
        check("t4_stall_locked", cpu_stall, 1);
        t1 = cyc;
        dbg_lock = 1'b0;
      end
    join
    cnt_c = 0; cnt_d = 0;
    for (int i = base; i < evs.size(); i++) begin
      if (evs[i].cyc > t0 && evs[i].cyc <= t1) begin
        if (evs[i].id == 0) cnt_c++; else cnt_d++;
      end
    end
    check("t4_lock_window", t1 - t0, 12);
    check("t4_dbg_acks", cnt_d, 4);
    check("t4_cpu_acks", cnt_c, 0);
    check("t4_next_grant_cpu", evs[evs.size() - 1].id, 0);

    // CPU keeps req high after ack: second transaction, ack 3 cycles later
    base = evs.size();
    issue(0, 1'b0, 32'h100, 0, 3'b010);
    issue(0, 1'b0, 32'h40, 0, 3'b010);
    check("t5_ack_count", evs.size() - base, 2);
    if (evs.size() - base == 2) check("t5_ack_spacing", evs[base + 1].cyc - evs[base].cyc, 3);

    // randomized traffic with random lock windows
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        rand_issue(0);
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        rand_issue(1);
      end
      for (int i = 0; i < 10; i++) begin
        repeat ($urandom_range(2, 8)) tick();
        dbg_lock = 1'b1;
        repeat ($urandom_range(0, 4)) tick();
        dbg_lock = 1'b0;
      end
    join
    dbg_lock = 1'b0;
    repeat (4) tick();

    // reset asserted during a CPU write's BUSY cycle
    cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hAA55AA55; cpu_size = 3'b010;
    cpu_req = 1'b1;
    tick();
    check("t7_busy_we", mem_write_enable, 1);
    check("t7_busy_waddr", mem_write_address, 32'h80);
    #2 rst = 1'b0;
    #1;
    check("t7_we_async_drop", mem_write_enable, 0);
    check("t7_waddr_zero", mem_write_address, 0);
    check("t7_wdata_zero", mem_write_data, 0);
    check("t7_no_ack", cpu_ack, 0);
    cpu_req = 1'b0;
    tick();
    check("t7_no_ack_after_edge", cpu_ack, 0);
    check("t7_rdata_zero", cpu_rdata, 0);
    check("t7_no_write", tb_mem[32], ref_mem[32]);
    rst = 1'b1;
    tick();
    base = evs.size();
    fork
      issue(0, 1'b0, 32'h80, 0, 3'b010);
      issue(1, 1'b0, 32'h100, 0, 3'b010);
    join
    check("t7_ack_count", evs.size() - base, 2);
    if (evs.size() > base) check("t7_first_tie_cpu", evs[base].id, 0);

    repeat (4) tick();
    check("cpu_q_drained", cpu_q.size(), 0);
    check("dbg_q_drained", dbg_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
